// File: rtl/tl_pkg.sv
// Shared types and constants for the two-road traffic-light phase scheduler:
// state encoding, lamp codes, display-select codes and the lamp decoder.
package tl_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_MG   = 3'd1,
    ST_MY   = 3'd2,
    ST_ARA  = 3'd3,
    ST_SG   = 3'd4,
    ST_SY   = 3'd5,
    ST_ARB  = 3'd6
  } state_e;

  localparam logic [2:0] RYG_R   = 3'b100;
  localparam logic [2:0] RYG_Y   = 3'b010;
  localparam logic [2:0] RYG_G   = 3'b001;
  localparam logic [2:0] RYG_ALL = 3'b111;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MAIN = 2'b01;
  localparam logic [1:0] SEL_SIDE = 2'b10;

  typedef struct packed {
    logic [2:0] ryg0;
    logic [2:0] ryg1;
    logic [1:0] sel;
  } lamp_t;

  // Unknown encodings show all lamps lit, same as INIT, until the FSM recovers.
  function automatic lamp_t decode_lamps(input state_e st);
    lamp_t l;
    l = '{ryg0: RYG_ALL, ryg1: RYG_ALL, sel: SEL_NONE};
    case (st)
      ST_MG:   l = '{ryg0: RYG_G, ryg1: RYG_R, sel: SEL_MAIN};
      ST_MY:   l = '{ryg0: RYG_Y, ryg1: RYG_R, sel: SEL_MAIN};
      ST_ARA:  l = '{ryg0: RYG_R, ryg1: RYG_R, sel: SEL_NONE};
      ST_SG:   l = '{ryg0: RYG_R, ryg1: RYG_G, sel: SEL_SIDE};
      ST_SY:   l = '{ryg0: RYG_R, ryg1: RYG_Y, sel: SEL_SIDE};
      ST_ARB:  l = '{ryg0: RYG_R, ryg1: RYG_R, sel: SEL_NONE};
      default: l = '{ryg0: RYG_ALL, ryg1: RYG_ALL, sel: SEL_NONE};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_countdown.sv
// Shared 6-bit phase countdown: loads on phase entry, otherwise counts down
// to 1 and sticks there; hold freezes the value.
module tl_countdown (
  input  logic       s_clk_1Hz,
  input  logic       rst_N,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       hold,
  output logic [5:0] cnt,
  output logic       expired
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  // NOTE: every path assigns cnt_d because it starts from cnt_q; without that
  // default, a missed branch would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q > 6'd1)) begin
      cnt_d = cnt_q - 6'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge s_clk_1Hz or negedge rst_N) begin
    if (!rst_N) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign expired = (cnt_q == 6'd1);

endmodule

// File: rtl/tl_phase_scheduler.sv
// Two-road traffic-light phase scheduler: phase FSM, pedestrian latch and
// Moore output decode around one shared countdown.
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int T_MAIN_GREEN = 60,
  parameter int T_SIDE_GREEN = 20,
  parameter int T_YELLOW     = 4,
  parameter int T_ALLRED     = 2,
  parameter int T_PED        = 15
) (
  input  logic       s_clk_1Hz,
  input  logic       rst_N,
  input  logic       car_side,
  input  logic       ped_req,
  input  logic       emerg,
  output logic [2:0] ryg0,
  output logic [2:0] ryg1,
  output logic       walk_main,
  output logic       ped_ack,
  output logic [5:0] cnt_value,
  output logic [1:0] cnt_sel,
  output logic [2:0] state_dbg
);

  localparam logic [5:0] T_MG = 6'(T_MAIN_GREEN);
  localparam logic [5:0] T_SG = 6'(T_SIDE_GREEN);
  localparam logic [5:0] T_Y  = 6'(T_YELLOW);
  localparam logic [5:0] T_AR = 6'(T_ALLRED);
  // Walk has been shown for T_PED ticks once the side-green count falls to this value.
  localparam logic [5:0] PED_DONE_CNT = 6'(T_SIDE_GREEN - T_PED + 1);

  state_e     state_q, state_d;
  logic       ped_pend_q, ped_pend_d;
  logic       ped_serv_q, ped_serv_d;
  logic [5:0] cnt;
  logic       expired;
  logic       cnt_load;
  logic       cnt_hold;
  logic [5:0] cnt_load_val;
  logic       sg_entry;
  logic       sg_exit;
  lamp_t      lamps;

  tl_countdown u_countdown (
    .s_clk_1Hz (s_clk_1Hz),
    .rst_N     (rst_N),
    .load      (cnt_load),
    .load_val  (cnt_load_val),
    .hold      (cnt_hold),
    .cnt       (cnt),
    .expired   (expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_ARB;
      ST_MG: begin
        if (expired && (car_side || ped_pend_q) && !emerg) state_d = ST_MY;
      end
      ST_MY: begin
        if (expired) state_d = ST_ARA;
      end
      ST_ARA: begin
        if (expired) state_d = emerg ? ST_MG : ST_SG;
      end
      ST_SG: begin
        if (expired || emerg ||
            (!car_side && (!ped_serv_q || (cnt <= PED_DONE_CNT)))) begin
          state_d = ST_SY;
        end
      end
      ST_SY: begin
        if (expired) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (expired) state_d = ST_MG;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Any change of state is a phase entry and reloads the countdown.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_hold     = (state_q == ST_MG) && emerg;
    cnt_load_val = 6'd0;
    case (state_d)
      ST_MG:   cnt_load_val = T_MG;
      ST_MY:   cnt_load_val = T_Y;
      ST_ARA:  cnt_load_val = T_AR;
      ST_SG:   cnt_load_val = T_SG;
      ST_SY:   cnt_load_val = T_Y;
      ST_ARB:  cnt_load_val = T_AR;
      default: cnt_load_val = 6'd0;
    endcase
  end

  // A request sampled on the SG entry edge stays pending for the next SG.
  always_comb begin
    sg_entry   = (state_d == ST_SG) && (state_q != ST_SG);
    sg_exit    = (state_q == ST_SG) && (state_d != ST_SG);
    ped_pend_d = ped_req || (ped_pend_q && !sg_entry);
    ped_serv_d = ped_serv_q;
    if (sg_entry) begin
      ped_serv_d = ped_pend_q;
    end else if (sg_exit) begin
      ped_serv_d = 1'b0;
    end
  end

  always_ff @(posedge s_clk_1Hz or negedge rst_N) begin
    if (!rst_N) begin
      state_q    <= ST_INIT;
      ped_pend_q <= 1'b0;
      ped_serv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      ped_serv_q <= ped_serv_d;
    end
  end

  // Moore decode: only registered state, count and pedestrian flags feed the outputs.
  always_comb begin
    lamps     = decode_lamps(state_q);
    ryg0      = lamps.ryg0;
    ryg1      = lamps.ryg1;
    cnt_sel   = lamps.sel;
    walk_main = (state_q == ST_SG) && ped_serv_q;
    ped_ack   = walk_main && (cnt == T_SG);
    cnt_value = cnt;
    state_dbg = state_q;
  end

endmodule
